// File: rtl/tl_mon_pkg.sv
// Shared TileLink monitor definitions: opcode encodings and the D-burst state enum.
package tl_mon_pkg;

  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

endpackage

// File: rtl/tl_beat_counter.sv
// D-channel beat tracker: sizes each message from size/opcode, follows
// multi-beat bursts and flags the last beat of a tracked message.
module tl_beat_counter
  import tl_mon_pkg::*;
#(
  parameter int unsigned SRC_BITS = 2,
  parameter int unsigned BEAT_LOG = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                d_fire,
  input  logic                start_ok,
  input  logic [SRC_BITS-1:0] d_source,
  input  logic [2:0]          d_size,
  input  logic [2:0]          d_opcode,
  output logic                first_beat_c,
  output logic                last_beat_c,
  output logic                src_mismatch_c,
  output logic [SRC_BITS-1:0] release_src_c
);

  localparam int unsigned CNT_W = 8 - BEAT_LOG;

  burst_state_e        state, next_state;
  logic [CNT_W-1:0]    count, next_count;
  logic [SRC_BITS-1:0] burst_src, next_src;
  logic                multi_c;
  logic [2:0]          shift_c;
  logic [CNT_W-1:0]    beats_m1_c;

  // Beat count of the message starting on this beat, minus one
  always_comb begin
    multi_c    = (d_opcode == ACCESS_ACK_DATA) && (d_size > 3'(BEAT_LOG));
    shift_c    = d_size - 3'(BEAT_LOG);
    beats_m1_c = (CNT_W'(1) << shift_c) - CNT_W'(1);
  end

  // Burst state, remaining-beat count and latched burst source
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      burst_src <= '0;
    end else begin
      state     <= next_state;
      count     <= next_count;
      burst_src <= next_src;
    end
  end

  // Next-state logic; only a first beat on a tracked source opens a burst
  always_comb begin
    next_state     = state;
    next_count     = count;
    next_src       = burst_src;
    first_beat_c   = 1'b0;
    last_beat_c    = 1'b0;
    src_mismatch_c = 1'b0;
    release_src_c  = d_source;
    case (state)
      IDLE: begin
        first_beat_c = d_fire;
        if (d_fire && start_ok) begin
          if (multi_c) begin
            next_state = BURST;
            next_src   = d_source;
            next_count = beats_m1_c;
          end else begin
            last_beat_c = 1'b1;
          end
        end
      end
      BURST: begin
        release_src_c = burst_src;
        if (d_fire) begin
          src_mismatch_c = (d_source != burst_src);
          next_count     = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            last_beat_c = 1'b1;
            next_state  = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/tl_inflight_tracker.sv
// Per-source in-flight tracker for a TileLink A/D channel pair; produces a
// registered size-compare pair and one-cycle protocol error pulses.
module tl_inflight_tracker
  import tl_mon_pkg::*;
#(
  parameter int unsigned SRC_BITS = 2,
  parameter int unsigned BEAT_LOG = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [SRC_BITS-1:0] a_source,
  input  logic [2:0]          a_size,
  input  logic [2:0]          a_opcode,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [SRC_BITS-1:0] d_source,
  input  logic [2:0]          d_size,
  input  logic [2:0]          d_opcode,
  output logic                chk_bypass,
  output logic [2:0]          chk_expect,
  output logic [2:0]          chk_actual,
  output logic                err_unexpected_d,
  output logic                err_source_reuse,
  output logic                err_opcode,
  output logic                err_burst_src,
  output logic                err_sticky
);

  localparam int unsigned NSRC = 1 << SRC_BITS;

  logic [NSRC-1:0]     inflight;
  logic [2:0]          size_q [NSRC];
  logic [NSRC-1:0]     exp_data;

  logic                a_fire_c, d_fire_c;
  logic                first_beat_c, last_beat_c, src_mismatch_c;
  logic [SRC_BITS-1:0] release_src_c;
  logic                d_tracked_c, first_ok_c, unexpected_c;
  logic                a_free_c, capture_c, reuse_c, opcode_bad_c;
  logic [2:0]          exp_opcode_c;

  tl_beat_counter #(
    .SRC_BITS (SRC_BITS),
    .BEAT_LOG (BEAT_LOG)
  ) u_beat_counter (
    .clock          (clock),
    .reset          (reset),
    .d_fire         (d_fire_c),
    .start_ok       (d_tracked_c),
    .d_source       (d_source),
    .d_size         (d_size),
    .d_opcode       (d_opcode),
    .first_beat_c   (first_beat_c),
    .last_beat_c    (last_beat_c),
    .src_mismatch_c (src_mismatch_c),
    .release_src_c  (release_src_c)
  );

  // Handshakes, first-beat classification and A-side capture decision
  always_comb begin
    a_fire_c     = a_valid & a_ready;
    d_fire_c     = d_valid & d_ready;
    d_tracked_c  = inflight[d_source];
    first_ok_c   = first_beat_c & d_tracked_c;
    unexpected_c = first_beat_c & ~d_tracked_c;
    exp_opcode_c = exp_data[d_source] ? ACCESS_ACK_DATA : ACCESS_ACK;
    opcode_bad_c = first_ok_c & (d_opcode != exp_opcode_c);
    // A source freed by a last beat this cycle may be reissued without error
    a_free_c     = ~inflight[a_source] | (last_beat_c & (release_src_c == a_source));
    capture_c    = a_fire_c & a_free_c;
    reuse_c      = a_fire_c & ~a_free_c;
  end

  // Per-source request table; a same-cycle capture overrides a release
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      exp_data <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        size_q[i] <= '0;
      end
    end else begin
      if (last_beat_c) begin
        inflight[release_src_c] <= 1'b0;
      end
      if (capture_c) begin
        inflight[a_source] <= 1'b1;
        size_q[a_source]   <= a_size;
        exp_data[a_source] <= (a_opcode == GET);
      end
    end
  end

  // Registered compare pair and error pulses, one cycle after the fire
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chk_bypass       <= 1'b1;
      chk_expect       <= '0;
      chk_actual       <= '0;
      err_unexpected_d <= 1'b0;
      err_source_reuse <= 1'b0;
      err_opcode       <= 1'b0;
      err_burst_src    <= 1'b0;
      err_sticky       <= 1'b0;
    end else begin
      chk_bypass       <= ~first_ok_c;
      chk_expect       <= first_ok_c ? size_q[d_source] : 3'd0;
      chk_actual       <= first_ok_c ? d_size : 3'd0;
      err_unexpected_d <= unexpected_c;
      err_source_reuse <= reuse_c;
      err_opcode       <= opcode_bad_c;
      err_burst_src    <= src_mismatch_c;
      err_sticky       <= err_sticky | unexpected_c | reuse_c | opcode_bad_c | src_mismatch_c;
    end
  end

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Bench for tl_inflight_tracker: directed vector table, reset-mid-burst
// sequence and randomized traffic against a message-level reference model.
module tb_tl_inflight_tracker;
  import tl_mon_pkg::*;

  localparam int BL = 3;

  typedef struct packed {
    logic       av;
    logic       ar;
    logic [1:0] asrc;
    logic [2:0] asz;
    logic [2:0] aop;
    logic       dv;
    logic       dr;
    logic [1:0] dsrc;
    logic [2:0] dsz;
    logic [2:0] dop;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [11:0] exp;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       a_valid, a_ready, d_valid, d_ready;
  logic [1:0] a_source, d_source;
  logic [2:0] a_size, a_opcode, d_size, d_opcode;
  logic       chk_bypass;
  logic [2:0] chk_expect, chk_actual;
  logic       err_unexpected_d, err_source_reuse, err_opcode, err_burst_src, err_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding requests and the beats still owed by an open response
  logic       m_inflight [4];
  logic [2:0] m_size     [4];
  logic       m_data     [4];
  int         m_rem;
  logic [1:0] m_bsrc;
  logic       m_sticky;

  tl_inflight_tracker #(
    .SRC_BITS (2),
    .BEAT_LOG (BL)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .a_valid          (a_valid),
    .a_ready          (a_ready),
    .a_source         (a_source),
    .a_size           (a_size),
    .a_opcode         (a_opcode),
    .d_valid          (d_valid),
    .d_ready          (d_ready),
    .d_source         (d_source),
    .d_size           (d_size),
    .d_opcode         (d_opcode),
    .chk_bypass       (chk_bypass),
    .chk_expect       (chk_expect),
    .chk_actual       (chk_actual),
    .err_unexpected_d (err_unexpected_d),
    .err_source_reuse (err_source_reuse),
    .err_opcode       (err_opcode),
    .err_burst_src    (err_burst_src),
    .err_sticky       (err_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic in_t mkin(input int av, ar, asrc, asz, aop, dv, dr, dsrc, dsz, dop);
    in_t v;
    v.av = 1'(av);   v.ar = 1'(ar);   v.asrc = 2'(asrc); v.asz = 3'(asz); v.aop = 3'(aop);
    v.dv = 1'(dv);   v.dr = 1'(dr);   v.dsrc = 2'(dsrc); v.dsz = 3'(dsz); v.dop = 3'(dop);
    return v;
  endfunction

  function automatic in_t a_in(input int src, sz, op);
    return mkin(1, 1, src, sz, op, 0, 0, 0, 0, 0);
  endfunction

  function automatic in_t d_in(input int src, sz, op);
    return mkin(0, 0, 0, 0, 0, 1, 1, src, sz, op);
  endfunction

  // Expected output word: bypass, expect, actual, unexp, reuse, opcode, burst_src, sticky
  function automatic logic [11:0] ex(input int byp, e, a, eu, er, eo, eb, st);
    return {1'(byp), 3'(e), 3'(a), 1'(eu), 1'(er), 1'(eo), 1'(eb), 1'(st)};
  endfunction

  function automatic vec_t row(input in_t i, input logic [11:0] e);
    vec_t r;
    r.in  = i;
    r.exp = e;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_inflight[i] = 1'b0;
      m_size[i]     = 3'd0;
      m_data[i]     = 1'b0;
    end
    m_rem    = 0;
    m_bsrc   = 2'd0;
    m_sticky = 1'b0;
  endtask

  // One clock of the model: returns the outputs expected after the edge
  task automatic model_step(input in_t v, output logic [11:0] e);
    logic       byp, eu, er, eo, eb, rel;
    logic [2:0] xe, xa;
    logic [1:0] rs;
    int         nb;
    byp = 1'b1; xe = 3'd0; xa = 3'd0;
    eu = 1'b0; er = 1'b0; eo = 1'b0; eb = 1'b0;
    rel = 1'b0; rs = 2'd0;
    if (v.dv && v.dr) begin
      if (m_rem > 0) begin
        eb    = (v.dsrc != m_bsrc);
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          rel = 1'b1;
          rs  = m_bsrc;
        end
      end else if (!m_inflight[v.dsrc]) begin
        eu = 1'b1;
      end else begin
        byp = 1'b0;
        xe  = m_size[v.dsrc];
        xa  = v.dsz;
        eo  = (v.dop != (m_data[v.dsrc] ? 3'd1 : 3'd0));
        nb  = (v.dop == 3'd1 && int'(v.dsz) > BL) ? (1 << (int'(v.dsz) - BL)) : 1;
        if (nb > 1) begin
          m_rem  = nb - 1;
          m_bsrc = v.dsrc;
        end else begin
          rel = 1'b1;
          rs  = v.dsrc;
        end
      end
    end
    if (rel) m_inflight[rs] = 1'b0;
    if (v.av && v.ar) begin
      if (m_inflight[v.asrc]) begin
        er = 1'b1;
      end else begin
        m_inflight[v.asrc] = 1'b1;
        m_size[v.asrc]     = v.asz;
        m_data[v.asrc]     = (v.aop == 3'd4);
      end
    end
    m_sticky = m_sticky | eu | er | eo | eb;
    e = {byp, xe, xa, eu, er, eo, eb, m_sticky};
  endtask

  task automatic drive(input in_t v);
    a_valid = v.av;   a_ready = v.ar;   a_source = v.asrc; a_size = v.asz; a_opcode = v.aop;
    d_valid = v.dv;   d_ready = v.dr;   d_source = v.dsrc; d_size = v.dsz; d_opcode = v.dop;
  endtask

  task automatic apply(input in_t v, output logic [11:0] e);
    drive(v);
    model_step(v, e);
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [11:0] exp);
    logic [11:0] got;
    got = {chk_bypass, chk_expect, chk_actual, err_unexpected_d, err_source_reuse,
           err_opcode, err_burst_src, err_sticky};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (bypass|expect|actual|unexp|reuse|opcode|burst_src|sticky)",
               nm, got, exp);
    end
  endtask

  initial begin
    vec_t        tbl [28];
    logic [11:0] e;
    logic [11:0] idle0, idle1;
    in_t         r;
    int          sel;

    idle0 = ex(1, 0, 0, 0, 0, 0, 0, 0);
    idle1 = ex(1, 0, 0, 0, 0, 0, 0, 1);

    reset = 1'b1;
    drive('0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_values", idle0);
    reset = 1'b0;

    // Single-beat Get round trip
    tbl[0]  = row('0,                                     idle0);
    tbl[1]  = row(a_in(1, 3, GET),                        idle0);
    tbl[2]  = row(d_in(1, 3, ACCESS_ACK_DATA),            ex(0, 3, 3, 0, 0, 0, 0, 0));
    // Four-beat burst, then source 2 reissued cleanly
    tbl[3]  = row(a_in(2, 5, GET),                        idle0);
    tbl[4]  = row(d_in(2, 5, ACCESS_ACK_DATA),            ex(0, 5, 5, 0, 0, 0, 0, 0));
    tbl[5]  = row(d_in(2, 5, ACCESS_ACK_DATA),            idle0);
    tbl[6]  = row(d_in(2, 5, ACCESS_ACK_DATA),            idle0);
    tbl[7]  = row(d_in(2, 5, ACCESS_ACK_DATA),            idle0);
    tbl[8]  = row(a_in(2, 4, GET),                        idle0);
    tbl[9]  = row(d_in(2, 4, ACCESS_ACK_DATA),            ex(0, 4, 4, 0, 0, 0, 0, 0));
    tbl[10] = row(d_in(2, 4, ACCESS_ACK_DATA),            idle0);
    // Source 1 already released
    tbl[11] = row(d_in(1, 0, ACCESS_ACK),                 ex(1, 0, 0, 1, 0, 0, 0, 1));
    // Burst with a foreign source on beat 3
    tbl[12] = row(a_in(2, 5, GET),                        idle1);
    tbl[13] = row(d_in(2, 5, ACCESS_ACK_DATA),            ex(0, 5, 5, 0, 0, 0, 0, 1));
    tbl[14] = row(d_in(2, 5, ACCESS_ACK_DATA),            idle1);
    tbl[15] = row(d_in(0, 5, ACCESS_ACK_DATA),            ex(1, 0, 0, 0, 0, 0, 1, 1));
    tbl[16] = row(d_in(2, 5, ACCESS_ACK_DATA),            idle1);
    tbl[17] = row(a_in(2, 1, GET),                        idle1);
    // Response to an idle source
    tbl[18] = row(d_in(3, 0, ACCESS_ACK),                 ex(1, 0, 0, 1, 0, 0, 0, 1));
    // Release and reissue of source 0 in the same cycle
    tbl[19] = row(a_in(0, 2, PUT_FULL),                   idle1);
    tbl[20] = row(mkin(1, 1, 0, 6, PUT_PARTIAL, 1, 1, 0, 2, ACCESS_ACK),
                                                          ex(0, 2, 2, 0, 0, 0, 0, 1));
    tbl[21] = row(a_in(0, 1, PUT_FULL),                   ex(1, 0, 0, 0, 1, 0, 0, 1));
    tbl[22] = row(d_in(0, 6, ACCESS_ACK),                 ex(0, 6, 6, 0, 0, 0, 0, 1));
    // Wrong response opcode for a Get
    tbl[23] = row(d_in(2, 1, ACCESS_ACK),                 ex(0, 1, 1, 0, 0, 1, 0, 1));
    // Stalled handshakes change nothing; size mismatch reported as a pair
    tbl[24] = row(a_in(3, 2, GET),                        idle1);
    tbl[25] = row(mkin(1, 0, 3, 2, GET, 1, 0, 3, 2, ACCESS_ACK_DATA), idle1);
    tbl[26] = row(d_in(3, 1, ACCESS_ACK_DATA),            ex(0, 2, 1, 0, 0, 0, 0, 1));
    tbl[27] = row(d_in(3, 1, ACCESS_ACK_DATA),            ex(1, 0, 0, 1, 0, 0, 0, 1));

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].in, e);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset in the middle of an eight-beat burst
    apply(a_in(1, 6, GET), e);
    check("burst8_get", idle1);
    apply(d_in(1, 6, ACCESS_ACK_DATA), e);
    check("burst8_beat1", ex(0, 6, 6, 0, 0, 0, 0, 1));
    apply(d_in(1, 6, ACCESS_ACK_DATA), e);
    check("burst8_beat2", idle1);
    apply(d_in(1, 6, ACCESS_ACK_DATA), e);
    check("burst8_beat3", idle1);
    drive('0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", idle0);
    @(posedge clock);
    #1;
    check("reset_hold", idle0);
    reset = 1'b0;
    model_reset();
    apply(d_in(1, 6, ACCESS_ACK_DATA), e);
    check("post_reset_first_beat", ex(1, 0, 0, 1, 0, 0, 0, 1));
    apply(a_in(1, 6, GET), e);
    check("post_reset_get", idle1);
    apply(d_in(1, 6, ACCESS_ACK_DATA), e);
    check("post_reset_compare", ex(0, 6, 6, 0, 0, 0, 0, 1));

    // Randomized traffic checked against the model
    for (int k = 0; k < 800; k++) begin
      r      = '0;
      r.av   = ($urandom_range(2) != 0);
      r.ar   = ($urandom_range(3) != 0);
      r.asrc = 2'($urandom_range(3));
      r.asz  = 3'($urandom_range(7));
      case ($urandom_range(2))
        0:       r.aop = GET;
        1:       r.aop = PUT_FULL;
        default: r.aop = PUT_PARTIAL;
      endcase
      r.dv = ($urandom_range(2) != 0);
      r.dr = ($urandom_range(3) != 0);
      if (m_rem > 0 && $urandom_range(9) != 0) r.dsrc = m_bsrc;
      else                                     r.dsrc = 2'($urandom_range(3));
      if ($urandom_range(1) != 0) r.dsz = m_size[r.dsrc];
      else                        r.dsz = 3'($urandom_range(7));
      sel = int'($urandom_range(19));
      if (sel < 10)      r.dop = m_data[r.dsrc] ? ACCESS_ACK_DATA : ACCESS_ACK;
      else if (sel < 19) r.dop = 3'($urandom_range(1));
      else               r.dop = 3'd2;
      apply(r, e);
      check($sformatf("rand%0d", k), e);
    end

    drive('0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
